// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, registered carry, LSB first.
// Define SERIAL_ADDER_SUB_EN to enable subtraction (b inverted, carry-in forced to 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_ld_c;
  logic             c_ld_c;
  logic             s_c;
  logic             co_c;
  logic             last_c;
  logic [WIDTH-1:0] acc_shift_c;

  // Operand conditioning applied once at capture time
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld_c = sub_i ? ~b_i : b_i;
  assign c_ld_c = sub_i ? 1'b1 : cin_i;
`else
  logic unused_sub;
  assign unused_sub = sub_i;
  assign b_ld_c     = b_i;
  assign c_ld_c     = cin_i;
`endif

  // Single full-adder cell on the current LSBs
  assign s_c    = a_q[0] ^ b_q[0] ^ c_q;
  assign co_c   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign last_c = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    acc_shift_c            = acc_q >> 1;
    acc_shift_c[WIDTH-1]   = s_c;
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_ld_c;
          c_d     = c_ld_c;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = co_c;
        acc_d = acc_shift_c;
        cnt_d = cnt_q + CW'(1);
        if (last_c) begin
          // c_q here is the carry into the MSB
          sum_d   = acc_shift_c;
          cout_d  = co_c;
          ovf_d   = c_q ^ co_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout, ovf;

  logic       rst1_n;
  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1, sub1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1, ovf1;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .sub_i(sub), .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start_i(start1), .a_i(a1), .b_i(b1), .cin_i(cin1),
    .sub_i(sub1), .busy_o(busy1), .done_o(done1), .sum_o(sum1), .cout_o(cout1), .ovf_o(ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vcin, input logic vsub,
                        input logic [7:0] es, input logic ec, input logic eo);
    int cycles;
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cycles = 0;
    while (!done && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_lat"}, 64'(cycles), 64'd8);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    step();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    last_sum = es;
  endtask

  initial begin
    int cycles;
    int pulses;
    rst_n = 1'b0; rst1_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;

    run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sovf_pos", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    run_op("sovf_neg", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_pos", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op("sub_cin_ign", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
`else
    run_op("sub_off", 8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    run_op("sub_off2", 8'h07, 8'h05, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    run_op("sub_off_cin", 8'h05, 8'h07, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
`endif

    // Busy lockout: second start during RUN is dropped
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    check("lock_hold_sum", 64'(sum), 64'(last_sum));
    check("lock_mid_done", 64'(done), 64'd0);
    cycles = 3;
    while (!done && cycles < 20) begin
      step();
      cycles++;
    end
    check("lock_lat", 64'(cycles), 64'd8);
    check("lock_sum", 64'(sum), 64'h30);
    check("lock_cout", 64'(cout), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) pulses++;
    end
    check("lock_no_second", 64'(pulses), 64'd0);

    // Reset mid-operation
    a = 8'h0F; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);
    run_op("after_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    // WIDTH=1 with start held high: period of three cycles
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    rst1_n = 1'b1;
    cycles = 0;
    while (!busy1 && cycles < 10) begin
      step();
      cycles++;
    end
    check("w1_first_accept", 64'(cycles), 64'd1);
    for (int r = 0; r < 3; r++) begin
      check("w1_busy", 64'(busy1), 64'd1);
      check("w1_run_done", 64'(done1), 64'd0);
      step();
      check("w1_done", 64'(done1), 64'd1);
      check("w1_busy_off", 64'(busy1), 64'd0);
      check("w1_sum", 64'(sum1), 64'd1);
      check("w1_cout", 64'(cout1), 64'd1);
      check("w1_ovf", 64'(ovf1), 64'd0);
      step();
      check("w1_idle_busy", 64'(busy1), 64'd0);
      check("w1_idle_done", 64'(done1), 64'd0);
      step();
    end
    start1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
